// File: rtl/double_dabble_bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble: shift right, then subtract 3 from digits >= 8).
// Define DD_BCD2BIN_PARALLEL_ADJ_EN to adjust all digits in one cycle instead of one digit per cycle.
module double_dabble_bcd2bin #(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [4*DIGITS-1:0]    bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_WIDTH-1:0]   bin_out,
    output logic                   invalid,
    output logic [1:0]             o_dbg_state
);

    localparam int SW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [1:0] IDLE_S  = 2'd0;
    localparam logic [1:0] SHIFT_S = 2'd1;
    localparam logic [1:0] ADJ_S   = 2'd2;
    localparam logic [1:0] DONE_S  = 2'd3;

    localparam logic [SW-1:0] L_LAST_SHIFT = SW'(BIN_WIDTH - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned L_BIN_RANGE = longint'(1) << BIN_WIDTH;
    localparam longint unsigned L_BCD_RANGE = pow10(DIGITS);

    generate
        if (DIGITS < 1 || L_BIN_RANGE < L_BCD_RANGE) begin : g_bad_params
            $error("double_dabble_bcd2bin: need DIGITS >= 1 and 2**BIN_WIDTH >= 10**DIGITS");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [BW-1:0]        r_bcd;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [SW-1:0]        r_shift_cnt;
    logic [BIN_WIDTH-1:0] r_bin_out;
    logic                 r_invalid;

    logic                 w_load_bad;
    logic                 w_last_shift;
    logic [BW-1:0]        w_shift_bcd;
    logic [BIN_WIDTH-1:0] w_shift_bin;
    logic [BW-1:0]        w_bcd_adj;

    always_comb begin
        w_load_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) w_load_bad = 1'b1;
        end
    end

    // The combined {bcd,bin} register moves right; the LSB of the BCD side feeds the binary MSB.
    assign w_shift_bcd  = {1'b0, r_bcd[BW-1:1]};
    assign w_shift_bin  = {r_bcd[0], r_bin[BIN_WIDTH-1:1]};
    assign w_last_shift = (r_shift_cnt == L_LAST_SHIFT);

`ifdef DD_BCD2BIN_PARALLEL_ADJ_EN
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd8) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] - 4'd3;
        end
    end
`else
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] L_LAST_DIGIT = DW'(DIGITS - 1);

    logic [DW-1:0] r_digit_idx;
    logic [3:0]    w_sel_digit;
    logic [3:0]    w_adj_digit;

    // One subtractor is shared: select the indexed digit, adjust it, write it back.
    always_comb begin
        w_sel_digit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_digit_idx == DW'(d)) w_sel_digit = r_bcd[4*d +: 4];
        end
        w_adj_digit = (w_sel_digit >= 4'd8) ? (w_sel_digit - 4'd3) : w_sel_digit;
        w_bcd_adj   = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_digit_idx == DW'(d)) w_bcd_adj[4*d +: 4] = w_adj_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_idx <= '0;
        end else if (en) begin
            case (r_state)
                IDLE_S:  if (start) r_digit_idx <= '0;
                SHIFT_S: if (!w_last_shift) r_digit_idx <= '0;
                ADJ_S:   r_digit_idx <= r_digit_idx + 1'b1;
                default: r_digit_idx <= r_digit_idx;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE_S;
            r_bcd       <= '0;
            r_bin       <= '0;
            r_shift_cnt <= '0;
            r_bin_out   <= '0;
            r_invalid   <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE_S: begin
                    if (start) begin
                        r_bcd       <= bcd_in;
                        r_bin       <= '0;
                        r_shift_cnt <= '0;
                        if (w_load_bad) begin
                            r_state   <= DONE_S;
                            r_bin_out <= '0;
                            r_invalid <= 1'b1;
                        end else begin
                            r_state <= SHIFT_S;
                        end
                    end
                end
                SHIFT_S: begin
                    r_bcd       <= w_shift_bcd;
                    r_bin       <= w_shift_bin;
                    r_shift_cnt <= r_shift_cnt + 1'b1;
                    if (w_last_shift) begin
                        r_state   <= DONE_S;
                        r_bin_out <= w_shift_bin;
                        r_invalid <= 1'b0;
                    end else begin
                        r_state <= ADJ_S;
                    end
                end
                ADJ_S: begin
                    r_bcd <= w_bcd_adj;
`ifdef DD_BCD2BIN_PARALLEL_ADJ_EN
                    r_state <= SHIFT_S;
`else
                    if (r_digit_idx == L_LAST_DIGIT) r_state <= SHIFT_S;
`endif
                end
                DONE_S:  r_state <= IDLE_S;
                default: r_state <= IDLE_S;
            endcase
        end
    end

    assign busy        = (r_state == SHIFT_S) || (r_state == ADJ_S) || (r_state == DONE_S);
    assign done        = (r_state == DONE_S) && en;
    assign bin_out     = r_bin_out;
    assign invalid     = r_invalid;
    assign o_dbg_state = r_state;

endmodule

// File: doc/double_dabble_bcd2bin.md
Name: double_dabble_bcd2bin

Overview:
- Sequential BCD-to-binary converter using the reverse double dabble algorithm. It is the inverse of the bin2bcd converter.
- Loads a packed DIGITS-digit BCD word, then repeats two steps: shift right, and adjust digits (subtract 3 from any digit >= 8). A controller FSM with a shift counter and a digit index sequences the work.
- Used on the operand-entry path so that decimal operands reach the radix-4 booth multiplier as binary.

Parameters:
- DIGITS, 4, number of BCD input digits (>= 1).
- BIN_WIDTH, 14, binary result width. Elaboration-time check: 2**BIN_WIDTH >= 10**DIGITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable. When low, all registers and the FSM hold.
- start  in  1  request conversion. Sampled only in IDLE_S with en=1.
- bcd_in  in  4*DIGITS  packed BCD, digit 0 = bits [3:0].
- busy  out  1  high whenever state != IDLE_S.
- done  out  1  one enabled-cycle pulse; result valid.
- bin_out  out  BIN_WIDTH  registered result, held until the next done.
- invalid  out  1  registered; 1 if any loaded digit > 9. Updated with bin_out.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en): state=IDLE_S; bcd_reg=0, bin_reg=0, shift_cnt=0, digit_idx=0, bin_out=0, invalid=0. Thus busy=0 and done=0.
- Reset mid-conversion aborts immediately. No done is produced for the aborted conversion.
- Every register update below requires en=1. With en=0 nothing changes.
- Datapath registers:
  - bcd_reg [4*DIGITS], bin_reg [BIN_WIDTH].
  - shift_cnt, width clog2(BIN_WIDTH+1).
  - digit_idx, width clog2(DIGITS+1).
- IDLE_S:
  - start=1 loads bcd_reg=bcd_in, bin_reg=0, shift_cnt=0, digit_idx=0.
  - If any digit of bcd_in > 9, go to DONE_S with err flag set. Otherwise go to SHIFT_S.
  - start=0: stay.
- SHIFT_S:
  - {bcd_reg,bin_reg} shifts right by 1: bin_reg MSB gets bcd_reg[0], bcd_reg MSB gets 0.
  - shift_cnt increments.
  - If the shift just done is the BIN_WIDTH-th (old shift_cnt == BIN_WIDTH-1), go to DONE_S.
  - Otherwise go to ADJ_S with digit_idx=0.
- ADJ_S:
  - If digit[digit_idx] of bcd_reg >= 8, that digit becomes digit-3 (4-bit, no borrow out). Other digits are unchanged.
  - digit_idx increments.
  - If digit_idx == DIGITS-1, go to SHIFT_S. Otherwise stay in ADJ_S.
- Transition into DONE_S:
  - Normal path: bin_out <= bin_reg value after the final shift; invalid <= 0.
  - Err path: bin_out <= 0; invalid <= 1.
- DONE_S:
  - done = (state==DONE_S) && en.
  - Next state IDLE_S.
  - start is ignored during DONE_S and during every non-IDLE state. No queuing.
- Latency:
  - Measured from the edge that samples start to the cycle with done=1, with en held 1.
  - Normal: 1 + BIN_WIDTH + (BIN_WIDTH-1)*DIGITS. Defaults give 67.
  - Invalid input: 1.
- Back-to-back: earliest next start is sampled in the cycle after done, i.e. in IDLE_S.
- bcd_in only needs to be stable in the start cycle. It is captured into bcd_reg.
- Unused or illegal state encoding returns to IDLE_S. All outputs stay at their idle values.

Optional Feature:
- Macro: DD_BCD2BIN_PARALLEL_ADJ_EN.
- Defined:
  - ADJ_S adjusts all DIGITS digits in a single cycle and then goes to SHIFT_S.
  - digit_idx is not instantiated.
  - Normal latency is 2*BIN_WIDTH (28 for defaults).
- Undefined: digit-serial adjust as specified above, one adder shared across digits.
- Results, invalid handling, reset and en behaviour are identical in both builds.

Test Plan:
1. bcd_in=16'h0000, start 1 cycle -> busy=1 for 67 cycles, done at cycle 67, bin_out=0, invalid=0.
2. bcd_in=16'h9999 -> bin_out=14'h270F (9999) at done. Also 16'h1234 -> 14'd1234, and 16'h0008 -> 14'd8.
3. bcd_in=16'h12A4 -> done at cycle 1, invalid=1, bin_out=0. The next conversion of 16'h0042 gives invalid=0, bin_out=42.
4. During a 16'h5000 conversion, pulse start with bcd_in=16'h0001 at cycle 10 -> ignored; bin_out=5000, exactly one done pulse.
5. rst=1 at cycle 30 of a 16'h7777 conversion -> next cycle busy=0, done=0, bin_out=0, invalid=0, and no done follows. A restart with 16'h0042 then gives 42.
6. en low on alternate cycles with 16'h9999 -> done after 67 enabled cycles, a single one-cycle done, bin_out=9999. Repeat with DD_BCD2BIN_PARALLEL_ADJ_EN defined -> done at cycle 28, same results for all the vectors above.
